// File: rtl/riscv_pc_pkg.sv
// Shared definitions for the program-counter fetch stage: default vectors,
// FSM state encodings and next-PC select encodings.
package riscv_pc_pkg;

   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SEL_SEQ    = 2'd0,
      SEL_BRANCH = 2'd1,
      SEL_JAL    = 2'd2,
      SEL_JALR   = 2'd3
   } pc_sel_t;

   // A fetch address is legal only on a 4-byte boundary.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: picks the control-transfer target by
// priority (jalr > jump > branch_taken > sequential), provides pc + 4 for
// link values, and flags a misaligned non-sequential target.
module next_pc_calc
   import riscv_pc_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic        jalr,
   output logic [31:0] target,
   output logic [31:0] pc_plus4,
   output logic        misalign
);

   logic [31:0] rel_target;
   logic [31:0] jalr_target;
   pc_sel_t     sel;

   // All arithmetic wraps modulo 2^32; no carry is observed.
   assign pc_plus4    = pc + 32'd4;
   assign rel_target  = pc + imm;
   assign jalr_target = (rs1_data + imm) & ~32'h1;

   // Priority select of the next-PC source and its alignment check.
   always_comb begin
      // NOTE: every output gets a default before the branches so no path leaves one unassigned (no latch).
      sel    = SEL_SEQ;
      target = pc_plus4;
      if (jalr) begin
         sel    = SEL_JALR;
         target = jalr_target;
      end else if (jump) begin
         sel    = SEL_JAL;
         target = rel_target;
      end else if (branch_taken) begin
         sel    = SEL_BRANCH;
         target = rel_target;
      end
      misalign = (sel != SEL_SEQ) && is_misaligned(target);
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage in front of the instruction memory. Owns the PC,
// the BOOT/RUN/HALT sequencing, misaligned-target trapping to a fixed
// vector, and a free-running count of retired fetches.
module pc_fetch_unit
   import riscv_pc_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
   parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEF,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic             jump,
   input  logic             jalr,
   input  logic [31:0]      imm,
   input  logic [31:0]      rs1_data,
   input  logic             halt_req,
   input  logic             resume,
   output logic [31:0]      instr_address,
   output logic [31:0]      pc_plus4,
   output logic             pc_valid,
   output logic             misalign,
   output logic [31:0]      bad_target,
   output logic [CNT_W-1:0] retired_count
);

   state_t      state;
   logic [31:0] target;
   logic        target_misaligned;

   next_pc_calc u_next_pc_calc (
      .pc           (instr_address),
      .imm          (imm),
      .rs1_data     (rs1_data),
      .branch_taken (branch_taken),
      .jump         (jump),
      .jalr         (jalr),
      .target       (target),
      .pc_plus4     (pc_plus4),
      .misalign     (target_misaligned)
   );

   // FSM, PC register, trap capture and retired counter, all with registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled synchronously here, and every state element uses non-blocking assignment.
      if (rst) begin
         state         <= ST_BOOT;
         instr_address <= RESET_VEC;
         pc_valid      <= 1'b0;
         misalign      <= 1'b0;
         bad_target    <= 32'h0;
         retired_count <= '0;
      end else begin
         // The trap indication lasts exactly one cycle unless re-armed below.
         misalign <= 1'b0;
         unique case (state)
            ST_BOOT: begin
               state    <= ST_RUN;
               pc_valid <= 1'b1;
            end
            ST_RUN: begin
               // A stalled cycle holds the PC, does not retire and never traps;
               // halt_req is only honoured on a cycle that actually advances.
               if (!stall) begin
                  if (target_misaligned) begin
                     instr_address <= TRAP_VEC;
                     bad_target    <= target;
                     misalign      <= 1'b1;
                  end else begin
                     instr_address <= target;
                  end
                  retired_count <= retired_count + CNT_W'(1);
                  if (halt_req) begin
                     state    <= ST_HALT;
                     pc_valid <= 1'b0;
                  end
               end
            end
            ST_HALT: begin
               // PC frozen; resume takes priority over a concurrent halt_req.
               if (resume) begin
                  state    <= ST_RUN;
                  pc_valid <= 1'b1;
               end
            end
            default: begin
               state    <= ST_BOOT;
               pc_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations, then randomized stimulus, all compared every cycle against
// a behavioural model of the fetch stage.
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic        jump;
   logic        jalr;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        halt_req;
   logic        resume;
   logic [31:0] instr_address;
   logic [31:0] pc_plus4;
   logic        pc_valid;
   logic        misalign;
   logic [31:0] bad_target;
   logic [31:0] retired_count;

   int n_checks = 0;
   int n_pass   = 0;

   pc_fetch_unit #(
      .RESET_VEC (32'h0000_0000),
      .TRAP_VEC  (32'h0000_0100),
      .CNT_W     (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .jump          (jump),
      .jalr          (jalr),
      .imm           (imm),
      .rs1_data      (rs1_data),
      .halt_req      (halt_req),
      .resume        (resume),
      .instr_address (instr_address),
      .pc_plus4      (pc_plus4),
      .pc_valid      (pc_valid),
      .misalign      (misalign),
      .bad_target    (bad_target),
      .retired_count (retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // The stage is "running" (fetches execute), "halted", or in the single
   // boot cycle after reset. Outputs are what an observer sees after an edge.
   bit          m_ok = 1'b0;
   bit          m_running, m_halted;
   logic [31:0] m_pc, m_bad, m_cnt;
   bit          m_trap;

   always @(posedge clk) begin
      logic [31:0] tgt;
      bit          transfer;
      if (rst) begin
         m_ok = 1'b1; m_running = 1'b0; m_halted = 1'b0;
         m_pc = 32'h0; m_bad = 32'h0; m_cnt = 32'h0; m_trap = 1'b0;
      end else if (m_ok) begin
         m_trap = 1'b0;
         if (!m_running && !m_halted) begin
            m_running = 1'b1;
         end else if (m_halted) begin
            if (resume) begin m_halted = 1'b0; m_running = 1'b1; end
         end else if (!stall) begin
            transfer = jalr || jump || branch_taken;
            if (jalr)      tgt = (rs1_data + imm) & 32'hFFFF_FFFE;
            else if (jump || branch_taken) tgt = m_pc + imm;
            else           tgt = m_pc + 32'd4;
            if (transfer && (tgt % 4 != 0)) begin
               m_bad = tgt; m_pc = 32'h100; m_trap = 1'b1;
            end else begin
               m_pc = tgt;
            end
            m_cnt = m_cnt + 32'd1;
            if (halt_req) begin m_running = 1'b0; m_halted = 1'b1; end
         end
      end
   end

   // Compare every cycle, on the falling edge, once the model has seen reset.
   always @(negedge clk) begin
      if (m_ok) begin
         check("instr_address", instr_address, m_pc);
         check("pc_plus4",      pc_plus4,      m_pc + 32'd4);
         check("pc_valid",      {31'b0, pc_valid}, {31'b0, m_running});
         check("misalign",      {31'b0, misalign}, {31'b0, m_trap});
         check("bad_target",    bad_target,    m_bad);
         check("retired_count", retired_count, m_cnt);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit r, input bit s, input bit b, input bit j, input bit jr,
                        input logic [31:0] im, input logic [31:0] rs,
                        input bit h, input bit rsm);
      rst = r; stall = s; branch_taken = b; jump = j; jalr = jr;
      imm = im; rs1_data = rs; halt_req = h; resume = rsm;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Idle RUN cycle: sequential advance.
   task automatic seq();
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
      cyc();
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

      // 1: reset, boot cycle, then sequential fetch.
      cyc(); cyc();
      check("rst_pc", instr_address, 32'h0);
      check("rst_valid", {31'b0, pc_valid}, 32'h0);
      check("rst_cnt", retired_count, 32'h0);
      seq();                                   // BOOT -> RUN, PC stays
      check("boot_pc", instr_address, 32'h0);
      check("boot_valid", {31'b0, pc_valid}, 32'h1);
      seq(); check("seq_4", instr_address, 32'h4);
      seq(); check("seq_8", instr_address, 32'h8);
      seq(); check("seq_c", instr_address, 32'hC);
      check("cnt_3", retired_count, 32'd3);

      // 2: branch back and JAL forward.
      drive(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 0); cyc();
      check("br_8", instr_address, 32'h8);
      drive(0, 0, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, 0, 0); cyc();
      check("br_0", instr_address, 32'h0);
      drive(0, 0, 0, 1, 0, 32'h20, 32'h0, 0, 0); cyc();
      check("jal_20", instr_address, 32'h20);

      // 3: JALR aligned, then misaligned trap.
      drive(0, 0, 1, 1, 1, 32'h3, 32'h1001, 0, 0); cyc();
      check("jalr_1004", instr_address, 32'h1004);
      drive(0, 0, 0, 0, 1, 32'h1, 32'h1001, 0, 0); cyc();
      check("trap_pc", instr_address, 32'h100);
      check("trap_pulse", {31'b0, misalign}, 32'h1);
      check("trap_bad", bad_target, 32'h1002);
      seq();
      check("trap_clear", {31'b0, misalign}, 32'h0);
      check("bad_held", bad_target, 32'h1002);

      // 4: stall with a pending jump, including a misaligned one.
      drive(0, 0, 0, 1, 0, 32'h10 - 32'h104, 32'h0, 0, 0); cyc();
      check("to_10", instr_address, 32'h10);
      drive(0, 1, 0, 1, 0, 32'h2, 32'h0, 0, 0); cyc();
      check("stall_notrap", {31'b0, misalign}, 32'h0);
      drive(0, 1, 0, 1, 0, 32'h40, 32'h0, 0, 0); cyc(); cyc(); cyc();
      check("stall_hold", instr_address, 32'h10);
      check("stall_cnt", retired_count, 32'd10);
      drive(0, 0, 0, 1, 0, 32'h40, 32'h0, 0, 0); cyc();
      check("stall_release", instr_address, 32'h50);

      // 5: halt, frozen PC, halt_req+resume together, halt ignored under stall.
      drive(0, 0, 0, 1, 0, 32'h14 - 32'h50, 32'h0, 0, 0); cyc();
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0); cyc();
      check("halt_pc", instr_address, 32'h18);
      check("halt_valid", {31'b0, pc_valid}, 32'h0);
      drive(0, 0, 1, 0, 0, 32'h40, 32'h0, 1, 0); cyc();
      check("halt_frozen", instr_address, 32'h18);
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 1); cyc();
      check("resume_valid", {31'b0, pc_valid}, 32'h1);
      check("resume_pc", instr_address, 32'h18);
      drive(0, 1, 0, 0, 0, 32'h0, 32'h0, 1, 0); cyc();
      check("stall_halt_ign", {31'b0, pc_valid}, 32'h1);

      // 6: reset during HALT and during stall; PC wrap.
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0); cyc();
      drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1); cyc();
      check("rst_halt_pc", instr_address, 32'h0);
      check("rst_halt_cnt", retired_count, 32'h0);
      seq(); seq(); seq();
      drive(1, 1, 0, 1, 0, 32'h40, 32'h0, 0, 0); cyc();
      check("rst_stall_pc", instr_address, 32'h0);
      check("rst_stall_valid", {31'b0, pc_valid}, 32'h0);
      seq();
      drive(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0, 0, 0); cyc();
      check("pc_top", instr_address, 32'hFFFF_FFFC);
      check("plus4_wrap", pc_plus4, 32'h0);
      seq();
      check("pc_wrap", instr_address, 32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] r_imm, r_rs;
         r_imm = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                             : (32'($urandom_range(0, 64)) * 32'd4 - 32'd128);
         r_rs  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255)) * 32'd4;
         drive($urandom_range(0, 99) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0,
               r_imm, r_rs,
               $urandom_range(0, 15) == 0,
               $urandom_range(0, 3) == 0);
         cyc();
      end

      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
      cyc(); cyc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
